// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural Z/V/N flag register and registered branch-condition evaluator
module flag_cond_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_vld,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_out,
    input  logic        ovfl,
    input  logic        stall,
    input  logic        br_vld,
    input  logic [2:0]  ccc,
    output logic        Z,
    output logic        V,
    output logic        N,
    output logic        take,
    output logic        take_vld
);
    logic       upd_all;
    logic       upd_z;
    logic [7:0] cond;
    logic       decision;
    always_comb begin
        upd_all  = alu_vld && !stall && (opcode == 4'b0000 || opcode == 4'b0001);
        upd_z    = upd_all || (alu_vld && !stall &&
                   (opcode == 4'b0010 || opcode == 4'b0100 || opcode == 4'b0101 || opcode == 4'b0110));
        // indexed by ccc; decisions use the registered flags, so a same-cycle write is not seen
        cond     = {1'b1, V, N | Z, Z | ~N, N, ~Z & ~N, Z, ~Z};
        decision = cond[ccc];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Z        <= 1'b0;
            V        <= 1'b0;
            N        <= 1'b0;
            take     <= 1'b0;
            take_vld <= 1'b0;
        end else begin
            if (upd_z) Z <= (alu_out == 16'h0000);
            if (upd_all) begin
                N <= alu_out[15];
                V <= ovfl;
            end
            if (!stall) begin
                take_vld <= br_vld;
                if (br_vld) take <= decision;
            end
        end
    end
endmodule
